// File: rtl/dot_sequencer.sv
// Run sequencer for the dot-product engine: INIT -> LOAD -> COMPUTE -> DRAIN -> DONE,
// with Moore-decoded control strobes for the downstream memory controller.
module dot_sequencer #(
  parameter int Addr_Width       = 4,
  parameter int Ram_Depth        = 1 << Addr_Width,
  parameter int bits_Computation = 4,
  parameter int Nums_Computation = 1 << bits_Computation,
  parameter int Para_Deg         = 2,
  parameter int Drain_Cycles     = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic       load_valid,
  output logic       load_ready,
  output logic       Mem_reset,
  output logic       Comp_reset,
  output logic       Mem_Index_reset,
  output logic       load_from_file,
  output logic       Computing,
  output logic       busy,
  output logic       done,
  output logic [2:0] state_dbg
);

  localparam int Load_Beats = Ram_Depth / Para_Deg;
  localparam int Comp_Beats = Nums_Computation / Para_Deg;
  localparam int Cnt_Max_Lc = (Load_Beats > Comp_Beats) ? Load_Beats : Comp_Beats;
  localparam int Cnt_Max    = (Cnt_Max_Lc > Drain_Cycles) ? Cnt_Max_Lc : Drain_Cycles;
  localparam int Cnt_W      = (Cnt_Max < 2) ? 1 : $clog2(Cnt_Max + 1);

  localparam logic [Cnt_W-1:0] Load_Last  = Cnt_W'(Load_Beats - 1);
  localparam logic [Cnt_W-1:0] Comp_Last  = Cnt_W'(Comp_Beats - 1);
  localparam logic [Cnt_W-1:0] Drain_Last = (Drain_Cycles == 0) ? '0 : Cnt_W'(Drain_Cycles - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    LOAD    = 3'd2,
    COMPUTE = 3'd3,
    DRAIN   = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t           state, state_next;
  logic [Cnt_W-1:0] beat_cnt, cnt_next;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      beat_cnt <= '0;
    end else begin
      state    <= state_next;
      beat_cnt <= cnt_next;
    end
  end

  // NOTE: defaults first so every path assigns every variable and no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = beat_cnt;
    case (state)
      IDLE:    if (start) state_next = INIT;
      INIT:    state_next = LOAD;
      LOAD: begin
        if (load_valid) begin
          cnt_next = beat_cnt + 1'b1;
          if (beat_cnt == Load_Last) state_next = COMPUTE;
        end
      end
      COMPUTE: begin
        cnt_next = beat_cnt + 1'b1;
        if (beat_cnt == Comp_Last) state_next = (Drain_Cycles == 0) ? DONE : DRAIN;
      end
      DRAIN: begin
        cnt_next = beat_cnt + 1'b1;
        if (beat_cnt == Drain_Last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // abort outranks every normal transition but is meaningless in IDLE
    if (abort && state != IDLE) state_next = IDLE;

    // counter restarts from zero on every state entry
    if (state_next != state) cnt_next = '0;
  end

  assign Mem_reset       = (state == INIT);
  assign Comp_reset      = (state == INIT);
  assign Mem_Index_reset = (state == INIT);
  assign load_ready      = (state == LOAD);
  assign load_from_file  = (state == LOAD) && load_valid;
  assign Computing       = (state == COMPUTE);
  assign done            = (state == DONE);
  assign busy            = (state != IDLE);
  assign state_dbg       = state;

endmodule

// File: tb/tb_dot_sequencer.sv
// Directed bench for dot_sequencer: default instance plus a Para_Deg=4 / Drain_Cycles=0
// instance, observed through a select mux.
module tb_dot_sequencer;

  logic clk = 1'b0;
  logic reset_n, start, abort, load_valid, sel;
  logic start_a, start_b;

  logic       rdy_a, mr_a, cr_a, ir_a, lff_a, cmp_a, busy_a, done_a;
  logic [2:0] st_a;
  logic       rdy_b, mr_b, cr_b, ir_b, lff_b, cmp_b, busy_b, done_b;
  logic [2:0] st_b;

  logic       o_rdy, o_mr, o_cr, o_ir, o_lff, o_cmp, o_busy, o_done;
  logic [2:0] o_st;

  int n_cmp = 0;
  int n_err = 0;

  int load_n, comp_n, drain_n, done_n, init_n, ready_n, overlap;
  int done_at, first_comp, last_strobe, exit_comp_state, prev_state;
  int st_hist[64];
  int busy_hist[64];

  always #5 clk = ~clk;

  assign start_a = start && !sel;
  assign start_b = start && sel;

  dot_sequencer dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .abort(abort), .load_valid(load_valid),
    .load_ready(rdy_a), .Mem_reset(mr_a), .Comp_reset(cr_a), .Mem_Index_reset(ir_a),
    .load_from_file(lff_a), .Computing(cmp_a), .busy(busy_a), .done(done_a), .state_dbg(st_a)
  );

  dot_sequencer #(.Para_Deg(4), .Drain_Cycles(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .abort(abort), .load_valid(load_valid),
    .load_ready(rdy_b), .Mem_reset(mr_b), .Comp_reset(cr_b), .Mem_Index_reset(ir_b),
    .load_from_file(lff_b), .Computing(cmp_b), .busy(busy_b), .done(done_b), .state_dbg(st_b)
  );

  assign o_rdy  = sel ? rdy_b  : rdy_a;
  assign o_mr   = sel ? mr_b   : mr_a;
  assign o_cr   = sel ? cr_b   : cr_a;
  assign o_ir   = sel ? ir_b   : ir_a;
  assign o_lff  = sel ? lff_b  : lff_a;
  assign o_cmp  = sel ? cmp_b  : cmp_a;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_done = sel ? done_b : done_a;
  assign o_st   = sel ? st_b   : st_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {o_rdy, o_mr, o_cr, o_ir, o_lff, o_cmp, o_busy, o_done}, 0);
    check({tag, "_state"}, o_st, 0);
  endtask

  // Iteration c drives the inputs sampled by edge c and observes the state left by edge c-1.
  task automatic run(input int ncyc, input bit toggle, input int s1, input int s2, input int ab);
    load_n = 0; comp_n = 0; drain_n = 0; done_n = 0; init_n = 0; ready_n = 0; overlap = 0;
    done_at = -1; first_comp = -1; last_strobe = -1; exit_comp_state = -1; prev_state = 0;
    for (int c = 0; c < ncyc; c++) begin
      start      = (c == 0) || (c == s1) || (c == s2);
      abort      = (c == ab);
      load_valid = toggle ? (c % 2 == 0) : 1'b1;
      #1;
      st_hist[c]   = int'(o_st);
      busy_hist[c] = int'(o_busy);
      if (o_mr && o_cr && o_ir) init_n++;
      if (o_lff) begin load_n++; last_strobe = c; end
      if (o_rdy) ready_n++;
      if (o_cmp) begin comp_n++; if (first_comp < 0) first_comp = c; end
      if (o_st == 3'd4) drain_n++;
      if (o_done) begin done_n++; done_at = c; end
      if (o_lff && o_cmp) overlap++;
      if (prev_state == 3 && o_st != 3'd3) exit_comp_state = int'(o_st);
      prev_state = int'(o_st);
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    load_valid = 1'b0;
  endtask

  initial begin
    sel = 1'b0; reset_n = 1'b0; start = 1'b0; abort = 1'b0; load_valid = 1'b1;
    #3;
    check_all_zero("reset_a");
    sel = 1'b1;
    #1;
    check_all_zero("reset_b");
    sel = 1'b0;
    #8 reset_n = 1'b1;
    tick();
    check("idle_after_reset", o_st, 0);

    // nominal run
    run(24, 1'b0, -1, -1, -1);
    check("nom_init_pulses", init_n, 1);
    check("nom_init_cycle", st_hist[1], 1);
    check("nom_load_strobes", load_n, 8);
    check("nom_first_compute", first_comp, 10);
    check("nom_compute_beats", comp_n, 8);
    check("nom_drain_cycles", drain_n, 2);
    check("nom_done_count", done_n, 1);
    check("nom_done_latency", done_at, 20);
    check("nom_no_overlap", overlap, 0);
    check("nom_back_to_idle", st_hist[21], 0);

    // load stalls on alternate cycles
    run(32, 1'b1, -1, -1, -1);
    check("stall_strobes", load_n, 8);
    check("stall_load_cycles", ready_n, 15);
    check("stall_last_strobe", last_strobe, 16);
    check("stall_first_compute", first_comp, 17);
    check("stall_compute_beats", comp_n, 8);
    check("stall_done_latency", done_at, 27);

    // abort on the 4th compute cycle
    run(30, 1'b0, -1, -1, 13);
    check("abort_compute_beats", comp_n, 4);
    check("abort_state_next", st_hist[14], 0);
    check("abort_busy_next", busy_hist[14], 0);
    check("abort_no_done", done_n, 0);
    check("abort_no_extra_init", init_n, 1);

    // fresh run after abort, then async reset mid-LOAD
    run(5, 1'b0, -1, -1, -1);
    check("restart_init_cycle", st_hist[1], 1);
    check("restart_init_pulses", init_n, 1);
    load_valid = 1'b1;
    #1;
    check("midload_in_load", o_st, 2);
    #1 reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    #2 reset_n = 1'b1;
    tick(); tick(); tick();
    check("post_reset_stays_idle", o_st, 0);
    check("post_reset_not_busy", o_busy, 0);

    // start pulses during LOAD and DRAIN are ignored
    run(24, 1'b0, 5, 18, -1);
    check("ignore_done_count", done_n, 1);
    check("ignore_done_latency", done_at, 20);
    check("ignore_load_strobes", load_n, 8);
    check("ignore_compute_beats", comp_n, 8);
    check("ignore_init_pulses", init_n, 1);
    check("ignore_final_idle", st_hist[23], 0);

    // Para_Deg=4, Drain_Cycles=0 instance
    sel = 1'b1;
    #1;
    check("sweep_idle_before", o_st, 0);
    run(14, 1'b0, -1, -1, -1);
    check("sweep_load_strobes", load_n, 4);
    check("sweep_compute_beats", comp_n, 4);
    check("sweep_no_drain", drain_n, 0);
    check("sweep_compute_to_done", exit_comp_state, 5);
    check("sweep_done_latency", done_at, 10);
    check("sweep_back_to_idle", st_hist[11], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
